// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet TX control generator.
package eth_tx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DEST_ADDR,
    SRC_ADDR,
    LEN_TYPE,
    DATA,
    PAD,
    FCS,
    IFG
  } eth_tx_gen_state_t;

  localparam int cSFD_BYTES      = 1;
  localparam int cMAC_ADDR_BYTES = 6;
  localparam int cLEN_TYPE_BYTES = 2;
  localparam int cFCS_BYTES      = 4;

  // Width of the payload length status and of the per-field byte counter.
  localparam int cLEN_W = 11;

  // Clock cycles needed to move one byte over a PHY of the given width.
  function automatic int calc_cpb(input int data_w);
    return 8 / data_w;
  endfunction

endpackage

// File: rtl/eth_tx_ctrl_gen_if.sv
// Control bus between the TX controller, the payload FIFO and the datapath.
interface eth_tx_ctrl_gen_if;
  import eth_tx_pkg::*;

  logic                eth_pkt_rdy;
  logic                fifo_empty;
  logic                fifo_last;
  logic                fifo_rd;
  logic                tx_en;
  logic                crc_en;
  logic                pad_en;
  logic                byte_load;
  logic                pkt_done;
  logic                abort;
  logic                len_err;
  logic [cLEN_W-1:0]   payload_len;
  eth_tx_gen_state_t   tx_ctrl_fsm_state;

  // Controller side.
  modport master (
    input  eth_pkt_rdy, fifo_empty, fifo_last,
    output fifo_rd, tx_en, crc_en, pad_en, byte_load, pkt_done,
           abort, len_err, payload_len, tx_ctrl_fsm_state
  );

  // FIFO / datapath side.
  modport slave (
    output eth_pkt_rdy, fifo_empty, fifo_last,
    input  fifo_rd, tx_en, crc_en, pad_en, byte_load, pkt_done,
           abort, len_err, payload_len, tx_ctrl_fsm_state
  );

endinterface

// File: rtl/eth_tx_byte_timer.sv
// Byte timer: phase within a byte and byte index within the current field.
module eth_tx_byte_timer
  import eth_tx_pkg::*;
#(
  parameter int pCPB = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic [cLEN_W-1:0] field_len_i,
  output logic              phase_zero_o,
  output logic              byte_boundary_o,
  output logic              field_done_o
);

  logic [2:0]        phase_q, phase_d;
  logic [cLEN_W-1:0] byte_q, byte_d;

  assign phase_zero_o    = (phase_q == 3'd0);
  assign byte_boundary_o = (phase_q == 3'(pCPB - 1));
  assign field_done_o    = byte_boundary_o && (byte_q == field_len_i - cLEN_W'(1));

  // Advance phase every cycle and the byte index at each byte boundary.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    phase_d = phase_q;
    byte_d  = byte_q;
    if (clr_i) begin
      phase_d = '0;
      byte_d  = '0;
    end else if (byte_boundary_o) begin
      phase_d = '0;
      byte_d  = byte_q + cLEN_W'(1);
    end else begin
      phase_d = phase_q + 3'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (rst_i) begin
      phase_q <= '0;
      byte_q  <= '0;
    end else begin
      phase_q <= phase_d;
      byte_q  <= byte_d;
    end
  end

endmodule

// File: rtl/eth_tx_ctrl_gen.sv
// Ethernet TX frame sequencer: preamble through IFG, with padding,
// maximum-length truncation and underrun abort.
module eth_tx_ctrl_gen
  import eth_tx_pkg::*;
#(
  parameter int pDATA_W         = 2,
  parameter int pPREAMBLE_BYTES = 7,
  parameter int pMIN_PAYLOAD    = 46,
  parameter int pMAX_PAYLOAD    = 1500,
  parameter int pIFG_BYTES      = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  eth_tx_ctrl_gen_if.master bus
);

  localparam int cCPB = calc_cpb(pDATA_W);

  eth_tx_gen_state_t state_q, state_d;
  logic [cLEN_W-1:0] payload_len_q, payload_len_d;
  logic              pkt_done_q, pkt_done_d;
  logic [cLEN_W-1:0] field_len;
  logic [cLEN_W:0]   len_inc;
  logic              phase_zero, byte_boundary, field_done;

  // Restart the byte timer whenever the field changes, including an abort
  // that happens mid-byte.
  eth_tx_byte_timer #(.pCPB(cCPB)) u_timer (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clr_i           (state_d != state_q),
    .field_len_i     (field_len),
    .phase_zero_o    (phase_zero),
    .byte_boundary_o (byte_boundary),
    .field_done_o    (field_done)
  );

  assign len_inc               = {1'b0, payload_len_q} + (cLEN_W + 1)'(1);
  assign bus.payload_len       = payload_len_q;
  assign bus.pkt_done          = pkt_done_q;
  assign bus.tx_ctrl_fsm_state = state_q;

  // Length of the current field in bytes; DATA ends on FIFO events instead.
  always_comb begin
    field_len = '0;
    case (state_q)
      PREAMBLE:  field_len = cLEN_W'(pPREAMBLE_BYTES);
      SFD:       field_len = cLEN_W'(cSFD_BYTES);
      DEST_ADDR: field_len = cLEN_W'(cMAC_ADDR_BYTES);
      SRC_ADDR:  field_len = cLEN_W'(cMAC_ADDR_BYTES);
      LEN_TYPE:  field_len = cLEN_W'(cLEN_TYPE_BYTES);
      PAD:       field_len = cLEN_W'(pMIN_PAYLOAD) - payload_len_q;
      FCS:       field_len = cLEN_W'(cFCS_BYTES);
      IFG:       field_len = cLEN_W'(pIFG_BYTES);
      default:   field_len = '0;
    endcase
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    payload_len_d = payload_len_q;
    pkt_done_d    = 1'b0;
    bus.fifo_rd   = 1'b0;
    bus.tx_en     = 1'b0;
    bus.crc_en    = 1'b0;
    bus.pad_en    = 1'b0;
    bus.byte_load = 1'b0;
    bus.abort     = 1'b0;
    bus.len_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.eth_pkt_rdy && !bus.fifo_empty) begin
          state_d       = PREAMBLE;
          payload_len_d = '0;
        end
      end
      PREAMBLE, SFD, DEST_ADDR, SRC_ADDR, LEN_TYPE: begin
        bus.tx_en     = 1'b1;
        bus.byte_load = phase_zero;
        bus.crc_en    = (state_q != PREAMBLE) && (state_q != SFD);
        if (field_done) begin
          case (state_q)
            PREAMBLE:  state_d = SFD;
            SFD:       state_d = DEST_ADDR;
            DEST_ADDR: state_d = SRC_ADDR;
            SRC_ADDR:  state_d = LEN_TYPE;
            default:   state_d = DATA;
          endcase
        end
      end
      DATA: begin
        bus.tx_en     = 1'b1;
        bus.byte_load = phase_zero;
        if (phase_zero && bus.fifo_empty) begin
          // Underrun: drop the frame without FCS, still honour the IFG.
          bus.abort = 1'b1;
          state_d   = IFG;
        end else begin
          bus.crc_en = 1'b1;
          if (byte_boundary) begin
            bus.fifo_rd   = 1'b1;
            payload_len_d = (&payload_len_q) ? payload_len_q : len_inc[cLEN_W-1:0];
            if (bus.fifo_last) begin
              state_d = (len_inc < (cLEN_W + 1)'(pMIN_PAYLOAD)) ? PAD : FCS;
            end else if (len_inc == (cLEN_W + 1)'(pMAX_PAYLOAD)) begin
              bus.len_err = 1'b1;
              state_d     = FCS;
            end
          end
        end
      end
      PAD: begin
        bus.tx_en     = 1'b1;
        bus.crc_en    = 1'b1;
        bus.pad_en    = 1'b1;
        bus.byte_load = phase_zero;
        if (field_done) state_d = FCS;
      end
      FCS: begin
        bus.tx_en     = 1'b1;
        bus.byte_load = phase_zero;
        if (field_done) state_d = IFG;
      end
      IFG: begin
        if (field_done) begin
          state_d    = IDLE;
          pkt_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, status and done-pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      payload_len_q <= '0;
      pkt_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      payload_len_q <= payload_len_d;
      pkt_done_q    <= pkt_done_d;
    end
  end

endmodule

// File: doc/eth_tx_ctrl_gen.md
Name: eth_tx_ctrl_gen

Overview:
Parametrised successor to the Ethernet TX control FSM. Sequences one frame per request (preamble, SFD, DA, SA, len/type, payload, pad, FCS, inter-frame gap) on a byte-timed basis, for any PHY nibble width (RMII 2b, MII 4b, GMII 8b).
Sits between the TX payload FIFO and the TX datapath serializer/CRC block.
Adds behaviour the previous generation lacks: real minimum-frame padding, maximum-length truncation, underrun abort and an enforced IFG.

Parameters:
pDATA_W, 2, PHY bits per clock; legal values 2, 4 and 8. Cycles per byte CPB = 8/pDATA_W.
pPREAMBLE_BYTES, 7, preamble length in bytes.
pMIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are padded.
pMAX_PAYLOAD, 1500, maximum payload bytes before truncation.
pIFG_BYTES, 12, inter-frame gap in byte times.

Ports:
Clk  in  1  system clock (50 MHz for RMII)
Rst  in  1  reset, asynchronous, active-high
Eth_Pkt_Rdy  in  1  frame available in FIFO; level, sampled only in IDLE
Fifo_Empty  in  1  payload FIFO empty (FWFT FIFO)
Fifo_Last  in  1  current FWFT head byte is the last payload byte
Fifo_Rd  out  1  pop strobe, one cycle per payload byte
Tx_En  out  1  PHY transmit enable
Crc_En  out  1  CRC accumulate enable
Pad_En  out  1  datapath substitutes 0x00 for the FIFO byte
Byte_Load  out  1  pulse: serializer loads next byte
Pkt_Done  out  1  pulse: frame complete, including IFG
Abort  out  1  pulse: underrun abort
Len_Err  out  1  pulse: pMAX_PAYLOAD reached without Fifo_Last
Payload_Len  out  11  payload bytes popped in the current frame
Tx_Ctrl_FSM_State  out  eth_tx_gen_state_t  current state

Behaviour:
- Reset (async, immediate, any state, including mid-frame):
  - All outputs 0.
  - State IDLE.
  - Counters cleared.
  - No partial-frame resume.
- Counters:
  - rPhase counts 0..CPB-1 within a byte.
  - rByte counts bytes within a field.
  - A byte boundary is the cycle with rPhase == CPB-1.
  - All field transitions happen only on byte boundaries.
- IDLE:
  - If Eth_Pkt_Rdy=1 and Fifo_Empty=0, go to PREAMBLE next cycle. Tx_En=1 and Byte_Load=1 in that same next cycle (latency 1).
  - Eth_Pkt_Rdy with Fifo_Empty=1 is ignored.
- Byte_Load: 1 on rPhase==0 of every byte in PREAMBLE through FCS; 0 elsewhere.
- Field lengths (bytes):
  - PREAMBLE: pPREAMBLE_BYTES
  - SFD: 1
  - DEST_ADDR: 6
  - SRC_ADDR: 6
  - LEN_TYPE: 2
  - FCS: 4
  - IFG: pIFG_BYTES
- Crc_En: 1 from the first DEST_ADDR cycle through the last PAD/DATA cycle; 0 in FCS.
- DATA:
  - Fifo_Rd=1 on each byte boundary. This pops the head byte and increments Payload_Len (saturates at 2047).
  - At a boundary with Fifo_Last=1: go to PAD if Payload_Len+1 < pMIN_PAYLOAD, else go to FCS.
  - At a boundary with Payload_Len+1 == pMAX_PAYLOAD and Fifo_Last=0: Len_Err pulse, go to FCS. Upstream flushes the remainder.
  - Fifo_Empty=1 at rPhase==0 of a DATA byte (underrun): Abort pulse, Tx_En=0 next cycle, Crc_En=0, go to IFG. No FCS is sent; Pkt_Done is still issued after the IFG.
  - If Fifo_Last and the max-length condition occur together, Fifo_Last wins and there is no Len_Err.
- PAD:
  - Pad_En=1 and Fifo_Rd=0.
  - Byte count = pMIN_PAYLOAD − Payload_Len.
  - Then go to FCS.
- FCS: after 4 bytes, Tx_En=0 and go to IFG.
- IFG:
  - Tx_En=0.
  - After pIFG_BYTES×CPB cycles, Pkt_Done pulses one cycle and the state returns to IDLE.
  - Eth_Pkt_Rdy is not sampled during IFG.
- Payload_Len: cleared on the IDLE→PREAMBLE transition; holds its value through FCS/IFG for status readback.
- Unknown state: go to IDLE, all outputs 0.

Decomposition:
- Package eth_tx_pkg gets:
  - typedef enum eth_tx_gen_state_t {IDLE, PREAMBLE, SFD, DEST_ADDR, SRC_ADDR, LEN_TYPE, DATA, PAD, FCS, IFG}
  - byte constants cSFD_BYTES=1, cMAC_ADDR_BYTES=6, cLEN_TYPE_BYTES=2, cFCS_BYTES=4
  - function for CPB from pDATA_W
- One natural sub-module, eth_tx_byte_timer: owns rPhase and rByte, takes a field length, and produces byte_boundary and field_done.
- The FSM lives in eth_tx_ctrl_gen.

Test Plan:
1. pDATA_W=2, 10-byte payload, Fifo_Last on byte 10:
   - Tx_En high for 288 cycles (28+4+24+24+8+40+144+16).
   - Exactly 10 Fifo_Rd pulses.
   - Pad_En high for 144 cycles.
   - Payload_Len=10.
   - Pkt_Done 48 cycles after Tx_En falls.
2. pDATA_W=4, 60-byte payload: no PAD state visited, Tx_En high for 2×(7+1+14+60+4)=172 cycles, Crc_En low for exactly the last 8 Tx_En cycles.
3. pDATA_W=2, Fifo_Empty asserted before payload byte 5: Abort pulse, Tx_En low one cycle later, no FCS state, Pkt_Done 48 cycles later, Payload_Len=4.
4. pMAX_PAYLOAD=64, 80 bytes queued: Len_Err at the 64th pop, exactly 64 Fifo_Rd pulses, state reaches FCS then IFG then IDLE.
5. Rst asserted mid-DATA, asynchronous between clock edges: all outputs 0 and state IDLE before the next edge. After release with Eth_Pkt_Rdy=1, a fresh frame starts with PREAMBLE.
6. Eth_Pkt_Rdy held high across frames: the second PREAMBLE starts exactly 1 cycle after Pkt_Done, never during IFG.
